framebuffer_writer: RTL and testbench

Pixel sink for the draw pipeline: accepts the plot stream (x, y, color, plot) produced by the sprite drawers and commits each pixel into the frame RAM write port. Buffers bursts in a small FIFO with backpressure, discards off-screen pixels, and provides a full-screen clear sequence used between frames. Sits between the draw controller and the frame RAM scanned out by the VGA side.

---
 rtl/framebuffer_writer_if.sv | 19 +
 rtl/framebuffer_writer.sv | 117 +++++++++++
 tb/tb_framebuffer_writer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_writer_if.sv
// Pixel plot stream between the draw pipeline and the framebuffer writer.
// Transfer happens on a rising clock edge where plot && ready.
interface framebuffer_writer_if;
  logic [9:0] x;
  logic [9:0] y;
  logic [2:0] color;
  logic       plot;
  logic       ready;

  modport master (
    output x, y, color, plot,
    input  ready
  );

  modport slave (
    input  x, y, color, plot,
    output ready
  );
endinterface

// File: rtl/framebuffer_writer.sv
// Pixel sink: filters off-screen pixels, buffers bursts in a FIFO and
// commits them to the frame RAM write port; also runs full-screen clears.
module framebuffer_writer #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  framebuffer_writer_if.slave pix,
  input  logic              clear_req,
  input  logic [2:0]        clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  output logic [7:0]        drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(H_RES * V_RES - 1);
  localparam logic [9:0] X_LIM = 10'(H_RES);
  localparam logic [9:0] Y_LIM = 10'(V_RES);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic [1:0]        state;
  logic [22:0]       fifo [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic [2:0]        clr_color_q;
  logic [ADDR_W-1:0] clr_cnt;
  logic              full;
  logic              empty;
  logic              accept;
  logic              in_range;
  logic              push;
  logic              pop;
  logic [9:0]        pop_x;
  logic [9:0]        pop_y;
  logic [2:0]        pop_c;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign pix.ready = (state == RUN) && !full && reset_n;
  assign accept    = pix.plot && pix.ready;
  assign in_range  = (pix.x < X_LIM) && (pix.y < Y_LIM);
  assign push      = accept && in_range;
  assign pop       = ((state == RUN) || (state == DRAIN)) && !empty;
  assign {pop_x, pop_y, pop_c} = fifo[rd_ptr];
  assign clear_busy = (state != RUN);

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= {pix.x, pix.y, pix.color};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      clr_color_q <= '0;
      clr_cnt     <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      drop_count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (accept && !in_range && drop_count != 8'hff)
        drop_count <= drop_count + 1'b1;

      mem_we <= 1'b0;
      if (pop) begin
        mem_we   <= 1'b1;
        mem_addr <= ADDR_W'(pop_y) * ADDR_W'(H_RES)
                  + ADDR_W'(pop_x);
        mem_data <= pop_c;
      end

      case (state)
        RUN: begin
          if (clear_req) begin
            state       <= DRAIN;
            clr_color_q <= clear_color;
          end
        end
        DRAIN: begin
          // empty implies no pop on this edge
          if (empty) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          mem_we   <= 1'b1;
          mem_addr <= clr_cnt;
          mem_data <= clr_color_q;
          clr_cnt  <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench: full-size instance for plotting/filtering, 4x2 instance for
// clear sequencing; writes are matched against per-instance queues.
module tb_framebuffer_writer;

  typedef struct {
    logic [16:0] addr;
    logic [2:0]  data;
  } wr_t;

  logic clk;
  logic reset_n;

  framebuffer_writer_if if_a ();
  framebuffer_writer_if if_b ();

  logic        clr_a, clr_b;
  logic [2:0]  ccol_a, ccol_b;
  logic        busy_a, busy_b;
  logic [16:0] ma;
  logic [2:0]  mb;
  logic [2:0]  da, db;
  logic        we_a, we_b;
  logic [7:0]  drop_a, drop_b;

  wr_t q_a[$];
  wr_t q_b[$];

  int n_tests = 0;
  int n_fail  = 0;

  framebuffer_writer dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix        (if_a),
    .clear_req  (clr_a),
    .clear_color(ccol_a),
    .clear_busy (busy_a),
    .mem_addr   (ma),
    .mem_data   (da),
    .mem_we     (we_a),
    .drop_count (drop_a)
  );

  framebuffer_writer #(
    .H_RES(4), .V_RES(2), .ADDR_W(3), .FIFO_DEPTH(8)
  ) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix        (if_b),
    .clear_req  (clr_b),
    .clear_color(ccol_b),
    .clear_busy (busy_b),
    .mem_addr   (mb),
    .mem_data   (db),
    .mem_we     (we_b),
    .drop_count (drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plot_a(input logic [9:0] px, input logic [9:0] py,
                        input logic [2:0] pc);
    if_a.x = px; if_a.y = py; if_a.color = pc; if_a.plot = 1'b1;
    tick();
    if_a.plot = 1'b0;
  endtask

  task automatic plot_b(input logic [9:0] px, input logic [9:0] py,
                        input logic [2:0] pc);
    if_b.x = px; if_b.y = py; if_b.color = pc; if_b.plot = 1'b1;
    tick();
    if_b.plot = 1'b0;
  endtask

  task automatic exp_clear_b(input int n, input logic [2:0] c);
    for (int i = 0; i < n; i++) q_b.push_back('{17'(i), c});
  endtask

  always @(negedge clk) begin
    if (we_a) begin
      wr_t e;
      n_tests++;
      assert (q_a.size() > 0) else begin
        n_fail++;
        $error("FAIL a_unexp_wr observed addr=%0d expected no write", ma);
      end
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_addr", 32'(ma), 32'(e.addr));
        check("a_data", 32'(da), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (we_b) begin
      wr_t e;
      n_tests++;
      assert (q_b.size() > 0) else begin
        n_fail++;
        $error("FAIL b_unexp_wr observed addr=%0d expected no write", mb);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_addr", 32'(mb), 32'(e.addr));
        check("b_data", 32'(db), 32'(e.data));
      end
    end
  end

  initial begin
    logic found;
    reset_n = 1'b0;
    if_a.x = '0; if_a.y = '0; if_a.color = '0; if_a.plot = 1'b0;
    if_b.x = '0; if_b.y = '0; if_b.color = '0; if_b.plot = 1'b0;
    clr_a = 1'b0; ccol_a = '0;
    clr_b = 1'b0; ccol_b = '0;
    repeat (3) tick();

    check("rst_we",    32'(we_a),   0);
    check("rst_addr",  32'(ma),     0);
    check("rst_data",  32'(da),     0);
    check("rst_drop",  32'(drop_a), 0);
    check("rst_busy",  32'(busy_a), 0);
    check("rst_ready", 32'(if_a.ready), 0);
    reset_n = 1'b1;
    #1;
    check("rel_ready", 32'(if_a.ready), 1);

    // single pixel latency: pop edge after transfer, one-cycle pulse
    q_a.push_back('{17'd645, 3'b100});
    plot_a(10'd5, 10'd2, 3'b100);
    check("lat_we0", 32'(we_a), 0);
    tick();
    check("lat_we1", 32'(we_a), 1);
    check("lat_addr", 32'(ma), 645);
    tick();
    check("lat_we2", 32'(we_a), 0);
    check("lat_hold", 32'(ma), 645);

    plot_a(10'd320, 10'd0, 3'b111);
    plot_a(10'd0, 10'd240, 3'b111);
    repeat (2) tick();
    check("drop2", 32'(drop_a), 2);

    if_a.x = 10'd400; if_a.y = 10'd7; if_a.plot = 1'b1;
    repeat (300) tick();
    if_a.plot = 1'b0;
    check("drop_sat", 32'(drop_a), 255);

    q_a.push_back('{17'd76799, 3'b010});
    plot_a(10'd319, 10'd239, 3'b010);
    repeat (2) tick();
    check("drop_edge", 32'(drop_a), 255);

    // 20 back-to-back pixels with plot held high
    if_a.plot = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if_a.x = 10'(i * 3);
      if_a.y = 10'(i);
      if_a.color = 3'(i);
      q_a.push_back('{17'(i * 320 + i * 3), 3'(i)});
      check("b2b_ready", 32'(if_a.ready), 1);
      tick();
    end
    if_a.plot = 1'b0;
    repeat (3) tick();
    check("b2b_done", 32'(q_a.size()), 0);

    // 4x2: three pixels, clear_req on the third pixel's edge
    q_b.push_back('{17'd1, 3'd2});
    q_b.push_back('{17'd6, 3'd3});
    q_b.push_back('{17'd7, 3'd5});
    exp_clear_b(8, 3'b001);
    plot_b(10'd1, 10'd0, 3'd2);
    plot_b(10'd2, 10'd1, 3'd3);
    ccol_b = 3'b001; clr_b = 1'b1;
    plot_b(10'd3, 10'd1, 3'd5);
    clr_b = 1'b0;
    check("clr_busy", 32'(busy_b), 1);
    for (int i = 0; i < 40 && busy_b; i++) begin
      check("clr_ready_low", 32'(if_b.ready), 0);
      tick();
    end
    check("clr_end_busy", 32'(busy_b), 0);
    check("clr_end_addr", 32'(mb), 7);
    check("clr_end_we", 32'(we_b), 1);
    check("clr_end_ready", 32'(if_b.ready), 1);
    tick();
    check("clr_q_empty", 32'(q_b.size()), 0);

    // reset while the clear is at address 3
    exp_clear_b(4, 3'b110);
    ccol_b = 3'b110; clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (we_b && mb == 3'd3) found = 1'b1;
    end
    check("mid_seen", 32'(found), 1);
    reset_n = 1'b0;
    tick();
    check("mid_we", 32'(we_b), 0);
    check("mid_addr", 32'(mb), 0);
    check("mid_busy", 32'(busy_b), 0);
    check("mid_ready_rst", 32'(if_b.ready), 0);
    reset_n = 1'b1;
    #1;
    check("mid_ready", 32'(if_b.ready), 1);
    check("mid_q", 32'(q_b.size()), 0);
    q_b.push_back('{17'd6, 3'd7});
    plot_b(10'd2, 10'd1, 3'd7);
    repeat (3) tick();
    check("post_rst_wr", 32'(q_b.size()), 0);

    // clear_req repeated during CLEAR must not restart or extend it
    exp_clear_b(8, 3'b011);
    ccol_b = 3'b011; clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    repeat (4) tick();
    ccol_b = 3'b101; clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    for (int i = 0; i < 40 && busy_b; i++) tick();
    check("reclr_busy", 32'(busy_b), 0);
    repeat (4) tick();
    check("reclr_q", 32'(q_b.size()), 0);
    check("final_qa", 32'(q_a.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
